// File: rtl/seq_alu.sv
// Registered execute-stage ALU with start/busy/done handshake.
// MULT runs an iterative shift-add into architectural HI/LO.
module seq_alu #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4,
    parameter int CMD_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CMD_W-1:0]   exe_cmd,
    input  logic [WIDTH-1:0]   val1,
    input  logic [WIDTH-1:0]   val2,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   alu_out,
    output logic               zero,
    output logic               ovf,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    localparam logic [CMD_W-1:0] C_ADD  = CMD_W'(0);
    localparam logic [CMD_W-1:0] C_SUB  = CMD_W'(1);
    localparam logic [CMD_W-1:0] C_AND  = CMD_W'(2);
    localparam logic [CMD_W-1:0] C_OR   = CMD_W'(3);
    localparam logic [CMD_W-1:0] C_NOR  = CMD_W'(4);
    localparam logic [CMD_W-1:0] C_XOR  = CMD_W'(5);
    localparam logic [CMD_W-1:0] C_CLR  = CMD_W'(6);
    localparam logic [CMD_W-1:0] C_SLL  = CMD_W'(7);
    localparam logic [CMD_W-1:0] C_SRL  = CMD_W'(8);
    localparam logic [CMD_W-1:0] C_SRA  = CMD_W'(9);
    localparam logic [CMD_W-1:0] C_MULT = CMD_W'(10);
    localparam logic [CMD_W-1:0] C_MFHI = CMD_W'(11);
    localparam logic [CMD_W-1:0] C_MFLO = CMD_W'(12);

    typedef enum logic {IDLE, MUL} state_t;

    state_t               state, state_nxt;
    logic [SHAMT_W-1:0]   cnt;
    logic [2*WIDTH-1:0]   acc, mcand, acc_nxt;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     b_eff, sum, result;
    logic                 res_ovf, accept, is_mult, last;

    assign busy    = (state == MUL);
    assign accept  = (state == IDLE) && start;
    assign is_mult = (exe_cmd == C_MULT);
    assign last    = (cnt == SHAMT_W'(WIDTH-1));
    assign acc_nxt = mplier[0] ? acc + mcand : acc;

    // SUB goes through the same adder with a two's-complement operand
    assign b_eff = (exe_cmd == C_SUB) ? ~val2 + 1'b1 : val2;
    assign sum   = val1 + b_eff;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && is_mult) state_nxt = MUL;
            MUL:  if (last) state_nxt = IDLE;
        endcase
    end

    always_comb begin
        result  = '0;
        res_ovf = 1'b0;
        case (exe_cmd)
            C_ADD, C_SUB: begin
                result  = sum;
                res_ovf = (val1[WIDTH-1] == b_eff[WIDTH-1]) &&
                          (sum[WIDTH-1] != val1[WIDTH-1]);
            end
            C_AND:  result = val1 & val2;
            C_OR:   result = val1 | val2;
            C_NOR:  result = ~(val1 | val2);
            C_XOR:  result = val1 ^ val2;
            C_CLR:  result = '0;
            C_SLL:  result = val1 << shamt;
            C_SRL:  result = val1 >> shamt;
            C_SRA:  result = $signed(val1) >>> shamt;
            C_MFHI: result = hi;
            C_MFLO: result = lo;
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done    <= 1'b0;
            alu_out <= '0;
            zero    <= 1'b0;
            ovf     <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                if (is_mult) begin
                    mcand  <= {{WIDTH{1'b0}}, val1};
                    mplier <= val2;
                    acc    <= '0;
                    cnt    <= '0;
                end else begin
                    alu_out <= result;
                    zero    <= (result == '0);
                    ovf     <= res_ovf;
                    done    <= 1'b1;
                end
            end else if (busy) begin
                acc    <= acc_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (last) begin
                    hi      <= acc_nxt[2*WIDTH-1:WIDTH];
                    lo      <= acc_nxt[WIDTH-1:0];
                    alu_out <= acc_nxt[WIDTH-1:0];
                    zero    <= (acc_nxt[WIDTH-1:0] == '0);
                    ovf     <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu (WIDTH=16).
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  exe_cmd = '0;
    logic [15:0] val1 = '0;
    logic [15:0] val2 = '0;
    logic [3:0]  shamt = '0;
    logic        busy, done, zero, ovf;
    logic [15:0] alu_out, hi, lo;

    int checks = 0;
    int errors = 0;
    int n;

    seq_alu #(.WIDTH(16), .SHAMT_W(4), .CMD_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .exe_cmd(exe_cmd),
        .val1(val1), .val2(val2), .shamt(shamt),
        .busy(busy), .done(done), .alu_out(alu_out), .zero(zero),
        .ovf(ovf), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] c, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] s);
        start   = 1'b1;
        exe_cmd = c;
        val1    = a;
        val2    = b;
        shamt   = s;
        tick();
    endtask

    task automatic wait_mul();
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_flags", {28'd0, busy, done, zero, ovf}, 32'h0);
        chk("rst_alu", {16'd0, alu_out}, 32'h0);
        chk("rst_hilo", {hi, lo}, 32'h0);

        drive(4'd0, 16'h7FFF, 16'h0001, 4'd0);
        start = 1'b0;
        chk("add_res", {done, ovf, zero, alu_out}, {16'd0, 3'b110, 16'h8000});

        drive(4'd1, 16'h0005, 16'h0005, 4'd0);
        start = 1'b0;
        chk("sub_res", {done, ovf, zero, alu_out}, {16'd0, 3'b101, 16'h0000});

        drive(4'd9, 16'h8000, 16'h0000, 4'd4);
        chk("sra", {done, alu_out}, {15'd0, 1'b1, 16'hF800});
        drive(4'd8, 16'h8000, 16'h0000, 4'd4);
        chk("srl", {done, alu_out}, {15'd0, 1'b1, 16'h0800});
        drive(4'd7, 16'h0001, 16'h0000, 4'd4);
        chk("sll", {done, alu_out}, {15'd0, 1'b1, 16'h0010});
        start = 1'b0;
        tick();
        chk("shift_done_off", {31'd0, done}, 32'h0);

        drive(4'd10, 16'h1234, 16'h0100, 4'd0);
        start = 1'b0;
        chk("mul1_busy", {30'd0, busy, done}, 32'h2);
        wait_mul();
        chk("mul1_lat", n, 32'd16);
        chk("mul1_done", {15'd0, done, alu_out}, {15'd0, 1'b1, 16'h3400});
        chk("mul1_hilo", {hi, lo}, 32'h0012_3400);
        drive(4'd11, 16'h0000, 16'h0000, 4'd0);
        start = 1'b0;
        chk("mfhi", {15'd0, done, alu_out}, {15'd0, 1'b1, 16'h0012});

        drive(4'd10, 16'hFFFF, 16'hFFFF, 4'd0);
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            if (n == 3) begin
                start = 1'b1;
                exe_cmd = 4'd0;
                val1 = 16'h0101;
                val2 = 16'h0202;
            end else if (n == 4) begin
                start = 1'b0;
                val1 = 16'h5555;
                val2 = 16'hAAAA;
            end
            if (n > 0 && n < 16 && done) chk("mul2_early_done", 32'd1, 32'd0);
            tick();
            n++;
        end
        chk("mul2_lat", n, 32'd16);
        chk("mul2_hilo", {hi, lo}, 32'hFFFE_0001);
        chk("mul2_alu", {15'd0, done, alu_out}, {15'd0, 1'b1, 16'h0001});
        tick();
        chk("mul2_no_extra", {31'd0, done}, 32'h0);

        drive(4'd10, 16'h1234, 16'h5678, 4'd0);
        start = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_flags", {30'd0, busy, done}, 32'h0);
        chk("abort_hilo", {hi, lo}, 32'h0);
        chk("abort_alu", {16'd0, alu_out}, 32'h0);

        drive(4'd10, 16'h0003, 16'h0005, 4'd0);
        start = 1'b0;
        wait_mul();
        chk("mul3_lat", n, 32'd16);
        chk("mul3_hilo", {hi, lo}, 32'h0000_000F);

        drive(4'd13, 16'h0005, 16'h0006, 4'd0);
        start = 1'b0;
        chk("code13", {done, zero, alu_out}, {14'd0, 2'b11, 16'h0000});
        drive(4'd0, 16'h0001, 16'h0002, 4'd0);
        start = 1'b0;
        chk("add_pre_clr", {16'd0, alu_out}, 32'h0003);
        drive(4'd6, 16'h1111, 16'h2222, 4'd0);
        start = 1'b0;
        chk("clr", {done, zero, alu_out}, {14'd0, 2'b11, 16'h0000});

        drive(4'd10, 16'h0002, 16'h0003, 4'd0);
        start = 1'b0;
        repeat (15) tick();
        chk("edge_busy", {31'd0, busy}, 32'h1);
        drive(4'd0, 16'h0001, 16'h0001, 4'd0);
        start = 1'b0;
        chk("edge_done", {15'd0, done, alu_out}, {15'd0, 1'b1, 16'h0006});
        tick();
        chk("edge_dropped", {15'd0, done, alu_out}, {16'd0, 16'h0006});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
